// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx_pin, qualifies the start bit, samples each
// bit at its centre and hands the byte out on a valid/ready pair.
module uart_rx #(
    parameter int CLK_FRE   = 40,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    input  logic       rx_data_ready,
    output logic       rx_frame_error,
    output logic       rx_overrun,
    output logic [1:0] dbg_state_o
);

    localparam int CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
    localparam int HALF  = CYCLE / 2;
    localparam logic [15:0] HALF_M1  = 16'(HALF - 1);
    localparam logic [15:0] CYCLE_M1 = 16'(CYCLE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t      state_q;
    logic        rx_s1_q, rx_s_q, rx_d_q;
    logic [15:0] cycle_cnt_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic [7:0]  rx_data_q;
    logic        rx_valid_q;
    logic        frame_err_q;
    logic        overrun_q;
    logic        fall_edge;

    assign fall_edge = rx_d_q & ~rx_s_q;

    // Handshake: a byte is transferred on any clock edge where rx_data_valid and
    // rx_data_ready are both high; valid then drops unless a new byte lands the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rx_s1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_d_q      <= 1'b1;
            cycle_cnt_q <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_s1_q     <= rx_pin;
            rx_s_q      <= rx_s1_q;
            rx_d_q      <= rx_s_q;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            cycle_cnt_q <= cycle_cnt_q + 16'd1;
            if (rx_valid_q && rx_data_ready) begin
                rx_valid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (fall_edge) begin
                        state_q     <= S_START;
                        cycle_cnt_q <= '0;
                    end
                end
                S_START: begin
                    // A line that is high again at mid-start was only a glitch.
                    if (cycle_cnt_q == HALF_M1 && rx_s_q) begin
                        state_q     <= S_IDLE;
                        cycle_cnt_q <= '0;
                    end else if (cycle_cnt_q == CYCLE_M1) begin
                        state_q     <= S_DATA;
                        cycle_cnt_q <= '0;
                    end
                end
                S_DATA: begin
                    if (cycle_cnt_q == HALF_M1) begin
                        shift_q[bit_cnt_q] <= rx_s_q;
                    end
                    if (cycle_cnt_q == CYCLE_M1) begin
                        cycle_cnt_q <= '0;
                        if (bit_cnt_q == 3'd7) begin
                            state_q   <= S_STOP;
                            bit_cnt_q <= '0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    // Leaving at mid-stop lets a zero-gap next start edge be caught.
                    if (cycle_cnt_q == HALF_M1) begin
                        state_q     <= S_IDLE;
                        cycle_cnt_q <= '0;
                        if (rx_s_q) begin
                            rx_data_q  <= shift_q;
                            rx_valid_q <= 1'b1;
                            overrun_q  <= rx_valid_q & ~rx_data_ready;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    cycle_cnt_q <= '0;
                end
            endcase
        end
    end

    assign rx_data        = rx_data_q;
    assign rx_data_valid  = rx_valid_q;
    assign rx_frame_error = frame_err_q;
    assign rx_overrun     = overrun_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: drives serial frames with real-valued bit times and
// checks received bytes, pulses and latency against a byte-level model.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int  CLK_FRE   = 1;
    localparam int  BAUD_RATE = 31250;
    localparam int  CYCLE     = CLK_FRE * 1000000 / BAUD_RATE;
    localparam int  HALF      = CYCLE / 2;
    localparam int  LAT       = 2 + 9 * CYCLE + HALF;
    localparam real CLK_NS    = 10.0;
    localparam real BIT_NS    = CYCLE * CLK_NS;
    localparam int  N_RAND    = 100;

    logic       clk;
    logic       rst_n;
    logic       rx_pin;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ready;
    logic       rx_frame_error;
    logic       rx_overrun;
    logic [1:0] dbg_state_o;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         rise_q[$];
    int         vhigh_cnt, fe_cnt, ov_cnt;
    logic       valid_prev = 1'b0;
    logic [7:0] last_byte;

    uart_rx #(.CLK_FRE(CLK_FRE), .BAUD_RATE(BAUD_RATE)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_pin         (rx_pin),
        .rx_data        (rx_data),
        .rx_data_valid  (rx_data_valid),
        .rx_data_ready  (rx_data_ready),
        .rx_frame_error (rx_frame_error),
        .rx_overrun     (rx_overrun),
        .dbg_state_o    (dbg_state_o)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #(CLK_NS / 2.0) clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: samples on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_data_valid) vhigh_cnt++;
            if (rx_data_valid && !valid_prev) rise_q.push_back(cyc);
            if (rx_data_valid && rx_data_ready) got_q.push_back(rx_data);
            if (rx_frame_error) fe_cnt++;
            if (rx_overrun) ov_cnt++;
        end
        valid_prev = rx_data_valid;
    end

    task automatic clear_mon();
        got_q.delete();
        exp_q.delete();
        rise_q.delete();
        vhigh_cnt = 0;
        fe_cnt    = 0;
        ov_cnt    = 0;
    endtask

    // Driver: start bit, 8 data bits LSB first, stop bit; line is left at the stop level
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input real bit_ns);
        rx_pin = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx_pin = b[i];
            #(bit_ns);
        end
        rx_pin = stop_bit;
        #(bit_ns);
    endtask

    task automatic idle_cycles(input int n);
        rx_pin = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx_pin = 1'b1;
        rx_data_ready = 1'b1;
        last_byte = 8'h00;
        clear_mon();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset rx_data: got %h exp 00", rx_data); end
        n_checks++; if (rx_data_valid !== 1'b0) begin n_fail++; $display("FAIL reset valid: got %b exp 0", rx_data_valid); end
        n_checks++; if (rx_frame_error !== 1'b0) begin n_fail++; $display("FAIL reset frame_error: got %b exp 0", rx_frame_error); end
        n_checks++; if (rx_overrun !== 1'b0) begin n_fail++; $display("FAIL reset overrun: got %b exp 0", rx_overrun); end
        n_checks++; if (dbg_state_o !== 2'd0) begin n_fail++; $display("FAIL reset state: got %0d exp 0 (idle)", dbg_state_o); end
    endtask

    task automatic test_single();
        int t0, r;
        clear_mon();
        exp_q.push_back(8'h55);
        last_byte = 8'h55;
        @(negedge clk);
        t0 = cyc;
        send_frame(8'h55, 1'b1, BIT_NS);
        idle_cycles(CYCLE);
        r = (rise_q.size() > 0) ? rise_q[0] : -1;
        n_checks++; if (rise_q.size() != 1) begin n_fail++; $display("FAIL single valid rises: got %0d exp 1", rise_q.size()); end
        n_checks++; if (r != t0 + 1 + LAT) begin n_fail++; $display("FAIL single latency: valid at cycle %0d exp %0d", r, t0 + 1 + LAT); end
        n_checks++; if (vhigh_cnt != 1) begin n_fail++; $display("FAIL single valid width: got %0d cycles exp 1", vhigh_cnt); end
        n_checks++; if (fe_cnt != 0 || ov_cnt != 0) begin n_fail++; $display("FAIL single err pulses: fe %0d ov %0d exp 0 0", fe_cnt, ov_cnt); end
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL single count: got %0d exp %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL single byte %0d: got %h exp %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        bytes[0] = 8'hA3; bytes[1] = 8'h00; bytes[2] = 8'hFF;
        clear_mon();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(bytes[i]);
            last_byte = bytes[i];
            send_frame(bytes[i], 1'b1, BIT_NS);
        end
        idle_cycles(CYCLE);
        n_checks++; if (rise_q.size() != 3) begin n_fail++; $display("FAIL b2b valid rises: got %0d exp 3", rise_q.size()); end
        n_checks++; if (fe_cnt != 0 || ov_cnt != 0) begin n_fail++; $display("FAIL b2b err pulses: fe %0d ov %0d exp 0 0", fe_cnt, ov_cnt); end
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b count: got %0d exp %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL b2b byte %0d: got %h exp %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_glitch();
        clear_mon();
        @(negedge clk);
        rx_pin = 1'b0;
        repeat (HALF / 2) @(negedge clk);
        n_checks++; if (dbg_state_o !== 2'd1) begin n_fail++; $display("FAIL glitch start seen: state %0d exp 1", dbg_state_o); end
        rx_pin = 1'b1;
        idle_cycles(2 * CYCLE);
        n_checks++; if (dbg_state_o !== 2'd0) begin n_fail++; $display("FAIL glitch state: got %0d exp 0 (idle)", dbg_state_o); end
        n_checks++; if (vhigh_cnt != 0 || fe_cnt != 0 || ov_cnt != 0) begin
            n_fail++; $display("FAIL glitch outputs: valid %0d fe %0d ov %0d exp 0 0 0", vhigh_cnt, fe_cnt, ov_cnt);
        end
        exp_q.push_back(8'h3C);
        last_byte = 8'h3C;
        @(negedge clk);
        send_frame(8'h3C, 1'b1, BIT_NS);
        idle_cycles(CYCLE);
        n_checks++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            n_fail++; $display("FAIL glitch follow byte: got %0d bytes first %h exp 1 byte %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, exp_q[0]);
        end
    endtask

    task automatic test_frame_error();
        clear_mon();
        @(negedge clk);
        send_frame(8'h81, 1'b0, BIT_NS);
        idle_cycles(2 * CYCLE);
        n_checks++; if (fe_cnt != 1) begin n_fail++; $display("FAIL ferr pulse cycles: got %0d exp 1", fe_cnt); end
        n_checks++; if (vhigh_cnt != 0) begin n_fail++; $display("FAIL ferr valid cycles: got %0d exp 0", vhigh_cnt); end
        n_checks++; if (rx_data !== last_byte) begin n_fail++; $display("FAIL ferr rx_data kept: got %h exp %h", rx_data, last_byte); end
        exp_q.push_back(8'h42);
        last_byte = 8'h42;
        @(negedge clk);
        send_frame(8'h42, 1'b1, BIT_NS);
        idle_cycles(CYCLE);
        n_checks++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            n_fail++; $display("FAIL ferr follow byte: got %0d bytes first %h exp 1 byte %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, exp_q[0]);
        end
        n_checks++; if (fe_cnt != 1 || ov_cnt != 0) begin n_fail++; $display("FAIL ferr follow pulses: fe %0d ov %0d exp 1 0", fe_cnt, ov_cnt); end
    endtask

    task automatic test_overrun();
        clear_mon();
        rx_data_ready = 1'b0;
        @(negedge clk);
        send_frame(8'h11, 1'b1, BIT_NS);
        send_frame(8'h22, 1'b1, BIT_NS);
        last_byte = 8'h22;
        idle_cycles(CYCLE);
        n_checks++; if (ov_cnt != 1) begin n_fail++; $display("FAIL ovr pulse cycles: got %0d exp 1", ov_cnt); end
        n_checks++; if (rx_data !== 8'h22) begin n_fail++; $display("FAIL ovr rx_data: got %h exp 22", rx_data); end
        n_checks++; if (rx_data_valid !== 1'b1) begin n_fail++; $display("FAIL ovr valid held: got %b exp 1", rx_data_valid); end
        n_checks++; if (fe_cnt != 0 || got_q.size() != 0) begin n_fail++; $display("FAIL ovr extras: fe %0d accepted %0d exp 0 0", fe_cnt, got_q.size()); end
        exp_q.push_back(8'h22);
        @(posedge clk);
        #1 rx_data_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (rx_data_valid !== 1'b0) begin n_fail++; $display("FAIL ovr valid clear: got %b exp 0", rx_data_valid); end
        n_checks++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            n_fail++; $display("FAIL ovr accepted byte: got %0d bytes first %h exp 1 byte %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, exp_q[0]);
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_mon();
        @(negedge clk);
        fork
            send_frame(8'h96, 1'b1, BIT_NS);
            begin
                #(BIT_NS * 5.5);
                rst_n = 1'b0;
                #1;
                n_checks++; if (rx_data_valid !== 1'b0 || dbg_state_o !== 2'd0 || rx_data !== 8'h00) begin
                    n_fail++; $display("FAIL midrst abort: valid %b state %0d data %h exp 0 0 00", rx_data_valid, dbg_state_o, rx_data);
                end
            end
        join
        rx_pin = 1'b1;
        last_byte = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(CYCLE);
        exp_q.push_back(8'h5A);
        last_byte = 8'h5A;
        @(negedge clk);
        send_frame(8'h5A, 1'b1, BIT_NS);
        idle_cycles(CYCLE);
        n_checks++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            n_fail++; $display("FAIL midrst follow byte: got %0d bytes first %h exp 1 byte %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, exp_q[0]);
        end
        n_checks++; if (fe_cnt != 0 || ov_cnt != 0) begin n_fail++; $display("FAIL midrst pulses: fe %0d ov %0d exp 0 0", fe_cnt, ov_cnt); end
    endtask

    task automatic test_random_baud();
        logic [7:0] b;
        real        e;
        int         bad;
        clear_mon();
        bad = 0;
        @(negedge clk);
        for (int i = 0; i < N_RAND; i++) begin
            b = 8'($urandom_range(0, 255));
            e = (real'(int'($urandom_range(0, 600))) - 300.0) / 10000.0;
            exp_q.push_back(b);
            last_byte = b;
            send_frame(b, 1'b1, BIT_NS * (1.0 + e));
            rx_pin = 1'b1;
            #(CLK_NS * $urandom_range(0, 3));
        end
        idle_cycles(2 * CYCLE);
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand count: got %0d exp %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++; bad++;
                if (bad <= 5) $display("FAIL rand byte %0d: got %h exp %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
        n_checks++; if (fe_cnt != 0 || ov_cnt != 0) begin n_fail++; $display("FAIL rand pulses: fe %0d ov %0d exp 0 0", fe_cnt, ov_cnt); end
        n_checks++; if (rx_data !== last_byte) begin n_fail++; $display("FAIL rand last rx_data: got %h exp %h", rx_data, last_byte); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_reset_mid_frame();
        test_random_baud();
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
